program_counter: RTL and testbench
==================================

Name: program_counter

Overview:
- Stage-1 (fetch) program counter register of the pipelined RISC-V core.
- Each cycle it holds its value, advances by 4, or loads a redirect target computed by the ALU.
- `pc_out` is a registered output that drives the instruction-memory address and the downstream pipeline.

Parameters:
- RESET_PC, 32'h0000_2000, value loaded into the PC on reset.
- WIDTH, 32, PC and target width in bits. Fixed at 32 for this core.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset asserted).
- stall  input  1  1 = hold current PC value.
- pc_sel  input  1  next-PC select: 0 = PC+4, 1 = alu_out.
- alu_out  input  32  redirect target from the ALU (jump/branch target).
- pc_out  output  32  current program counter, registered.

Behaviour:
- All updates occur on the rising edge of clk. There is no asynchronous path.
- Update priority at each rising edge, highest first:
  1. reset == 0 → pc_out <= RESET_PC. This overrides stall and pc_sel.
  2. stall == 1 → pc_out <= pc_out (hold). pc_sel and alu_out are ignored.
  3. pc_sel == 1 → pc_out <= alu_out, loaded unchanged (no bit masking or alignment).
  4. pc_sel == 0 → pc_out <= pc_out + 32'd4.
- Latency: inputs sampled at edge N appear on pc_out immediately after edge N, one register delay. They are stable within one fifth of a clock period.
- pc_out changes only at rising clock edges. Input changes between edges have no effect.
- Reset value: pc_out = RESET_PC after the first edge with reset low.
- Before any reset edge, pc_out is undefined; no power-on value is required.
- Reset held low for multiple cycles keeps pc_out at RESET_PC.
- Reset deasserted: the first edge with reset high applies the stall/pc_sel rules to RESET_PC.
- Reset asserted mid-run (including while stalled or with pc_sel=1): the next edge forces RESET_PC.
- Increment wraps modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000. No overflow flag.
- A misaligned alu_out (low bits non-zero) is loaded as-is. Alignment checking belongs elsewhere.
- Stall held for K cycles keeps pc_out constant for K cycles. On the first unstalled edge the PC advances or redirects normally.
- Redirect and stall in the same cycle: stall wins and the redirect is dropped. Upstream control must re-present the redirect.
- Optional X on inputs: no masking is required.

Test Plan:
- Reset: reset=0 for 2 cycles with stall=1, pc_sel=1, alu_out=32'hDEAD_BEEF → pc_out = 32'h0000_2000 after each edge.
- Sequential fetch: release reset, stall=0, pc_sel=0 for 4 cycles → pc_out = 2004, 2008, 200C, 2010 (hex).
- Redirect: pc_sel=1, alu_out=32'h0000_3A40 → pc_out = 3A40. Next cycle pc_sel=0 → 3A44.
- Stall: from pc_out=3A44, stall=1 for 3 cycles with pc_sel=1, alu_out=32'h1234_5678 → pc_out stays 3A44. Then stall=0, pc_sel=0 → 3A48.
- Wrap and misaligned load: pc_sel=1, alu_out=32'hFFFF_FFFC, then pc_sel=0 → pc_out = FFFF_FFFC, then 0000_0000. Then pc_sel=1, alu_out=32'h0000_1003 → 0000_1003.
- Reset mid-run: with pc_out=0000_1003, drive reset=0 together with stall=0, pc_sel=1, alu_out=5555_5554 → pc_out = 0000_2000.

Source files
------------

// File: rtl/program_counter_if.sv
// Fetch-stage control bundle: hold/redirect controls in, current PC out.
// The pipeline control side uses the master modport, the PC register the slave.
interface program_counter_if #(
   parameter int WIDTH = 32
);
   logic             stall;
   logic             pc_sel;
   logic [WIDTH-1:0] alu_out;
   logic [WIDTH-1:0] pc_out;

   modport master (
      output stall,
      output pc_sel,
      output alu_out,
      input  pc_out
   );

   modport slave (
      input  stall,
      input  pc_sel,
      input  alu_out,
      output pc_out
   );
endinterface

// File: rtl/program_counter.sv
// Stage-1 fetch program counter: holds, advances by 4, or loads an ALU redirect target.
// pc_out is registered and feeds the instruction-memory address directly.
module program_counter #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_2000
) (
   input logic                clk,
   input logic                reset,
   program_counter_if.slave   bus
);

   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] pc_next;

   // Stall outranks a redirect: a dropped redirect must be re-presented upstream.
   // The increment wraps modulo 2^WIDTH and redirect targets are loaded unaligned.
   always_comb begin
      pc_next = pc_q + WIDTH'(4);
      if (bus.stall) begin
         pc_next = pc_q;
      end else if (bus.pc_sel) begin
         pc_next = bus.alu_out;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_next;
      end
   end

   assign bus.pc_out = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed plan with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_program_counter;

   localparam logic [31:0] RESET_PC = 32'h0000_2000;

   logic clk;
   logic reset;

   program_counter_if #(.WIDTH(32)) bus ();

   program_counter #(
      .WIDTH   (32),
      .RESET_PC(RESET_PC)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] model_pc;
   bit          model_valid = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: next PC from the priority rules, computed on each rising edge.
   always @(posedge clk) begin
      if (reset === 1'b0) begin
         model_pc    = RESET_PC;
         model_valid = 1'b1;
      end else if (model_valid) begin
         if (bus.stall === 1'b1) model_pc = model_pc;
         else if (bus.pc_sel === 1'b1) model_pc = bus.alu_out;
         else model_pc = model_pc + 32'd4;
      end
   end

   // Outputs are compared mid-period, well away from the active edge.
   always @(negedge clk) begin
      if (model_valid) begin
         checks++;
         if (bus.pc_out !== model_pc) begin
            failures++;
            $display("[TB] FAIL model_cmp t=%0t pc_out=%h expected=%h", $time, bus.pc_out, model_pc);
         end
      end
   end

   task automatic applyStimulus(input logic rst_v, input logic stall_v,
                                input logic sel_v, input logic [31:0] alu_v);
      reset       = rst_v;
      bus.stall   = stall_v;
      bus.pc_sel  = sel_v;
      bus.alu_out = alu_v;
      @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] expected);
      checks++;
      if (bus.pc_out !== expected) begin
         failures++;
         $display("[TB] FAIL %s pc_out=%h expected=%h", name, bus.pc_out, expected);
      end
   endtask

   initial begin
      reset       = 1'b1;
      bus.stall   = 1'b0;
      bus.pc_sel  = 1'b0;
      bus.alu_out = '0;
      @(negedge clk);

      applyStimulus(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
      checkOutput("reset_1", 32'h0000_2000);
      applyStimulus(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
      checkOutput("reset_2", 32'h0000_2000);

      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("fetch_1", 32'h0000_2004);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("fetch_2", 32'h0000_2008);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("fetch_3", 32'h0000_200C);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("fetch_4", 32'h0000_2010);

      applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_3A40);
      checkOutput("redirect", 32'h0000_3A40);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("post_redirect", 32'h0000_3A44);

      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b1, 32'h1234_5678);
         checkOutput($sformatf("stall_%0d", i), 32'h0000_3A44);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("unstall", 32'h0000_3A48);

      applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
      checkOutput("load_top", 32'hFFFF_FFFC);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("wrap", 32'h0000_0000);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_1003);
      checkOutput("misaligned", 32'h0000_1003);

      applyStimulus(1'b0, 1'b0, 1'b1, 32'h5555_5554);
      checkOutput("reset_midrun", 32'h0000_2000);

      // Random traffic, occasionally steering near the wrap point.
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] alu_v;
         alu_v = $urandom;
         if ($urandom_range(7) == 0) alu_v = 32'hFFFF_FFF0 | 32'($urandom_range(15));
         applyStimulus($urandom_range(31) != 0, $urandom_range(3) == 0,
                       $urandom_range(3) == 0, alu_v);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
